// File: rtl/pattern_buffer_writer.sv
// pattern_buffer_writer: test-pattern frame generator for the image-buffer write path.
// Ports: clock/reset_n; mode/solid_value/scroll/continuous config; start/start_ack and
// done/done_ack/overrun control handshake; dout/valid/ready stream {mask,frame,addr,pixels}.
module pattern_buffer_writer #(
    parameter int IMG_WIDTH    = 800,
    parameter int IMG_HEIGHT   = 600,
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int ADDR_W       = 17,
    parameter int CHK_LOG2     = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic [PIX_W-1:0]     solid_value,
    input  logic                 scroll,
    input  logic                 continuous,
    input  logic                 start,
    output logic                 start_ack,
    output logic                 done,
    input  logic                 done_ack,
    output logic                 overrun,
    output logic [PIX_PER_WORD+ADDR_W+PIX_PER_WORD*PIX_W:0] dout,
    output logic                 valid,
    input  logic                 ready
);

    localparam int WPR      = IMG_WIDTH / PIX_PER_WORD;
    localparam int MAX_ADDR = WPR * IMG_HEIGHT - 1;
    localparam int COL_W    = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int DATA_W   = PIX_PER_WORD * PIX_W;
    localparam int DOUT_W   = PIX_PER_WORD + 1 + ADDR_W + DATA_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                frame_q, frame_d;
    logic [PIX_W-1:0]    off_q, off_d;
    logic [1:0]          mode_q, mode_d;
    logic [PIX_W-1:0]    solid_q, solid_d;
    logic                scroll_q, scroll_d;
    logic                cont_q, cont_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;
    logic                valid_q, valid_d;
    logic [DOUT_W-1:0]   dout_q, dout_d;
    logic [2:0]          sync_q;

    logic launch;
    logic hs;
    logic frame_end;
    logic latch_cfg;
    logic [DATA_W-1:0] pix_d;

    // sync_q[1] is the synchronised start; sync_q[2] detects its rising edge
    assign start_ack = sync_q[1];
    assign launch    = sync_q[1] & ~sync_q[2];
    assign hs        = valid_q & ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        col_d     = col_q;
        row_d     = row_q;
        frame_d   = frame_q;
        off_d     = off_q;
        valid_d   = valid_q;
        frame_end = 1'b0;
        latch_cfg = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d   = RUN;
                    valid_d   = 1'b1;
                    addr_d    = '0;
                    col_d     = '0;
                    row_d     = '0;
                    latch_cfg = 1'b1;
                end
            end
            RUN: begin
                if (hs && addr_q == ADDR_W'(MAX_ADDR)) begin
                    frame_end = 1'b1;
                    frame_d   = ~frame_q;
                    off_d     = scroll_q ? off_q + PIX_W'(1) : '0;
                    addr_d    = '0;
                    col_d     = '0;
                    row_d     = '0;
                    // continuous frames restart with no bubble
                    if (cont_q) begin
                        latch_cfg = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else if (hs) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (col_q == COL_W'(WPR - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        solid_d  = solid_q;
        scroll_d = scroll_q;
        cont_d   = cont_q;
        if (latch_cfg) begin
            mode_d   = mode;
            solid_d  = solid_value;
            scroll_d = scroll;
            cont_d   = continuous;
        end
    end

    // a new frame end beats a simultaneous acknowledge
    always_comb begin
        done_d = done_q;
        ovr_d  = ovr_q;
        if (done_q && done_ack) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (frame_end) begin
            done_d = 1'b1;
            if (done_q && !done_ack) begin
                ovr_d = 1'b1;
            end
        end
    end

    // pixels are built from next-state position so dout is a pure register
    always_comb begin
        logic [31:0] xo;
        logic [31:0] yo;
        logic [31:0] ry;
        pix_d = '0;
        xo    = '0;
        ry    = 32'(row_d);
        yo    = ry + 32'(off_d);
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            xo = 32'(col_d) * 32'(PIX_PER_WORD) + 32'(k) + 32'(off_d);
            unique case (mode_d)
                2'd0: pix_d[k*PIX_W +: PIX_W] = xo[PIX_W-1:0];
                2'd1: pix_d[k*PIX_W +: PIX_W] = yo[PIX_W-1:0];
                2'd2: pix_d[k*PIX_W +: PIX_W] =
                          {PIX_W{xo[CHK_LOG2] ^ ry[CHK_LOG2]}};
                2'd3: pix_d[k*PIX_W +: PIX_W] = solid_d;
            endcase
        end
        dout_d = {{PIX_PER_WORD{1'b1}}, frame_d, addr_d, pix_d};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            frame_q  <= 1'b1;
            off_q    <= '0;
            mode_q   <= '0;
            solid_q  <= '0;
            scroll_q <= 1'b0;
            cont_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            valid_q  <= 1'b0;
            sync_q   <= '0;
            dout_q   <= {{PIX_PER_WORD{1'b1}}, 1'b1,
                         {(ADDR_W + DATA_W){1'b0}}};
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            frame_q  <= frame_d;
            off_q    <= off_d;
            mode_q   <= mode_d;
            solid_q  <= solid_d;
            scroll_q <= scroll_d;
            cont_q   <= cont_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            valid_q  <= valid_d;
            sync_q   <= {sync_q[1:0], start};
            dout_q   <= dout_d;
        end
    end

    assign done    = done_q;
    assign overrun = ovr_q;
    assign valid   = valid_q;
    assign dout    = dout_q;

endmodule

// File: tb/tb_pattern_buffer_writer.sv
// tb_pattern_buffer_writer: random and directed stimulus for pattern_buffer_writer,
// checked each cycle against a word-index reference model plus literal expectations.
module tb_pattern_buffer_writer;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int PPW  = 4;
    localparam int WPR  = W / PPW;
    localparam int N    = WPR * H;
    localparam int CHK  = 2;

    logic        clock;
    logic        reset_n;
    logic [1:0]  mode;
    logic [7:0]  solid_value;
    logic        scroll;
    logic        continuous;
    logic        start;
    logic        start_ack;
    logic        done;
    logic        done_ack;
    logic        overrun;
    logic [53:0] dout;
    logic        valid;
    logic        ready;

    int vectors = 0;
    int miscompares = 0;

    pattern_buffer_writer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8),
        .PIX_PER_WORD(PPW), .ADDR_W(17), .CHK_LOG2(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .mode(mode),
        .solid_value(solid_value), .scroll(scroll),
        .continuous(continuous), .start(start),
        .start_ack(start_ack), .done(done), .done_ack(done_ack),
        .overrun(overrun), .dout(dout), .valid(valid), .ready(ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int p,
            input logic [1:0] m, input logic [7:0] sv,
            input logic [7:0] off);
        logic [31:0] w;
        int col, row, x, o;
        w   = '0;
        col = p % WPR;
        row = p / WPR;
        o   = int'(off);
        for (int k = 0; k < PPW; k++) begin
            x = col * PPW + k;
            case (m)
                2'd0: w[k*8 +: 8] = 8'((x + o) % 256);
                2'd1: w[k*8 +: 8] = 8'((row + o) % 256);
                2'd2: w[k*8 +: 8] =
                    ((((x + o) / CHK) % 2) != ((row / CHK) % 2))
                    ? 8'hFF : 8'h00;
                default: w[k*8 +: 8] = sv;
            endcase
        end
        return w;
    endfunction

    // reference model: word index within frame, config snapshot
    logic [2:0] msync = '0;
    logic       mrun = 1'b0;
    int         mp = 0;
    logic       mframe = 1'b1;
    logic [7:0] moff = '0;
    logic [1:0] lmode = '0;
    logic [7:0] lsolid = '0;
    logic       lscroll = 1'b0;
    logic       lcont = 1'b0;
    logic       mdone = 1'b0;
    logic       movr = 1'b0;

    initial begin
        logic launch, hs, fend;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                msync = '0; mrun = 1'b0; mp = 0;
                mframe = 1'b1; moff = '0;
                mdone = 1'b0; movr = 1'b0;
            end
            chk("start_ack", 64'(start_ack), 64'(msync[1]));
            chk("valid", 64'(valid), 64'(mrun));
            chk("done", 64'(done), 64'(mdone));
            chk("overrun", 64'(overrun), 64'(movr));
            if (mrun)
                chk("dout", 64'(dout),
                    64'({4'hF, mframe, 17'(mp),
                         exp_pix(mp, lmode, lsolid, moff)}));
            if (reset_n) begin
                launch = msync[1] & ~msync[2];
                hs     = mrun & ready;
                fend   = hs && (mp == N - 1);
                if (fend) begin
                    if (mdone && !done_ack) movr = 1'b1;
                    else if (mdone) movr = 1'b0;
                    mdone = 1'b1;
                end else if (mdone && done_ack) begin
                    mdone = 1'b0;
                    movr  = 1'b0;
                end
                if (!mrun) begin
                    if (launch) begin
                        mrun = 1'b1; mp = 0;
                        lmode = mode; lsolid = solid_value;
                        lscroll = scroll; lcont = continuous;
                    end
                end else if (fend) begin
                    mframe = ~mframe;
                    moff = lscroll ? 8'(moff + 8'd1) : 8'h00;
                    mp = 0;
                    if (lcont) begin
                        lmode = mode; lsolid = solid_value;
                        lscroll = scroll; lcont = continuous;
                    end else begin
                        mrun = 1'b0;
                    end
                end else if (hs) begin
                    mp++;
                end
                msync = {msync[1:0], start};
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_word(input int a, input int f,
                             input logic [31:0] e, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clock);
            if (valid && dout[48:32] == 17'(a) &&
                (f < 0 || dout[49] == f[0]))
                hit = 1'b1;
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got timeout expected word %0d", nm, a);
        end else begin
            chk(nm, 64'(dout[31:0]), 64'(e));
        end
    endtask

    // which: 0 done high, 1 valid low, 2 overrun high
    task automatic wait_sig(input int which, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clock);
            case (which)
                0: hit = done;
                1: hit = !valid;
                default: hit = overrun;
            endcase
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got timeout expected event %0d", nm, which);
        end
    endtask

    task automatic start_lo();
        step();
        start = 1'b0;
        repeat (3) step();
    endtask

    task automatic ack();
        step();
        done_ack = 1'b1;
        step();
        done_ack = 1'b0;
    endtask

    initial begin
        int hsn;
        reset_n = 1'b0; mode = 2'd0; solid_value = 8'h00;
        scroll = 1'b0; continuous = 1'b0; start = 1'b0;
        done_ack = 1'b0; ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_sack", 64'(start_ack), 64'd0);

        // single frame, horizontal gradient
        step(); start = 1'b1;
        wait_word(0, 1, 32'h03020100, "A_w0");
        wait_word(1, 1, 32'h07060504, "A_w1");
        wait_word(4, 1, 32'h03020100, "A_w4");
        wait_word(7, 1, 32'h07060504, "A_w7");
        @(negedge clock);
        chk("A_done", 64'(done), 64'd1);
        chk("A_idle", 64'(valid), 64'd0);
        start_lo();
        ack();

        // ready toggling every cycle
        ready = 1'b0;
        start = 1'b1;
        hsn = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (valid && ready) hsn++;
            if (done) break;
            step();
            ready = ~ready;
            if (i == 8) start = 1'b0;
        end
        chk("B_hs", 64'(hsn), 64'(N));
        step(); start = 1'b0; ready = 1'b1;
        repeat (3) step();
        ack();

        // scrolling continuous frames, ack tied high
        scroll = 1'b1; continuous = 1'b1; done_ack = 1'b1;
        start = 1'b1;
        wait_word(0, 0, 32'h04030201, "C_f2w0");
        wait_word(0, 1, 32'h05040302, "C_f3w0");
        step(); continuous = 1'b0;
        start_lo();
        wait_sig(1, "C_stop");
        chk("C_ovr", 64'(overrun), 64'd0);
        repeat (2) step();
        done_ack = 1'b0; scroll = 1'b0;

        // overrun with no acknowledge
        continuous = 1'b1;
        start = 1'b1;
        wait_sig(2, "D_ovr");
        chk("D_ovr", 64'(overrun), 64'd1);
        chk("D_done", 64'(done), 64'd1);
        step(); continuous = 1'b0;
        start_lo();
        wait_sig(1, "D_stop");
        ack();
        @(negedge clock);
        chk("D_clr_done", 64'(done), 64'd0);
        chk("D_clr_ovr", 64'(overrun), 64'd0);

        // checkerboard
        step(); mode = 2'd2; start = 1'b1;
        wait_word(0, -1, 32'hFFFF0000, "E_r0");
        wait_word(4, -1, 32'h0000FFFF, "E_r2");
        wait_sig(0, "E_done");
        start_lo();
        ack();

        // solid
        mode = 2'd3; solid_value = 8'h5A; start = 1'b1;
        wait_word(0, -1, 32'h5A5A5A5A, "F_w0");
        wait_word(5, -1, 32'h5A5A5A5A, "F_w5");
        wait_sig(0, "F_done");
        start_lo();
        ack();

        // reset mid-frame
        mode = 2'd0; start = 1'b1;
        wait_word(2, -1, 32'h03020100, "G_w2");
        step();
        reset_n = 1'b0;
        #1;
        chk("G_valid", 64'(valid), 64'd0);
        chk("G_done", 64'(done), 64'd0);
        chk("G_sack", 64'(start_ack), 64'd0);
        start = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (2) step();
        start = 1'b1;
        wait_word(0, 1, 32'h03020100, "G_restart");
        wait_sig(0, "G_done2");
        start_lo();
        ack();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            ready       = ($urandom % 4) != 0;
            done_ack    = ($urandom % 8) == 0;
            mode        = 2'($urandom % 4);
            solid_value = 8'($urandom);
            scroll      = 1'($urandom % 2);
            continuous  = ($urandom % 4) == 0;
            if (($urandom % 10) == 0) start = ~start;
        end
        step();
        continuous = 1'b0; start = 1'b0; ready = 1'b1;
        wait_sig(1, "H_stop");
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_buffer_writer.md
Name: pattern_buffer_writer

Overview:
- Parametrised test-pattern frame generator that feeds the image-buffer write path.
- Produces one packed word per handshake in the form {byte mask, frame select, word address, pixel data}.
- Pixel width, pixels per word, image geometry and pattern mode are configurable; per-frame horizontal scroll and continuous (free-running) frames are supported.
- Sits between the control FSM (start/done handshake) and the frame-buffer write arbiter (valid/ready).

Parameters:
- IMG_WIDTH, 800, pixels per row; must be a multiple of PIX_PER_WORD.
- IMG_HEIGHT, 600, rows per frame.
- PIX_W, 8, bits per pixel.
- PIX_PER_WORD, 4, pixels packed per output word.
- ADDR_W, 17, word-address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT/PIX_PER_WORD.
- CHK_LOG2, 3, log2 of checkerboard square size in pixels.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  pattern select: 0 horizontal gradient, 1 vertical gradient, 2 checkerboard, 3 solid.
- solid_value  in  PIX_W  pixel value used in mode 3.
- scroll  in  1  advance the pattern offset by 1 per completed frame.
- continuous  in  1  restart automatically after each frame.
- start  in  1  asynchronous level request; synchronised internally.
- start_ack  out  1  synchronised copy of start.
- done  out  1  frame complete; held until acknowledged.
- done_ack  in  1  clears done.
- overrun  out  1  a frame completed while done was still set.
- dout  out  PIX_PER_WORD+1+ADDR_W+PIX_PER_WORD*PIX_W  {mask, frame, addr, pixels}.
- valid  out  1  dout holds a word.
- ready  in  1  downstream accepts the word.

Behaviour:
- Derived constants: WPR = IMG_WIDTH/PIX_PER_WORD; MAX_ADDR = WPR*IMG_HEIGHT-1.
- Reset values (asynchronous, while reset_n=0): state IDLE, addr 0, col 0, row 0, frame 1, offset 0, start_ack 0, done 0, overrun 0, valid 0.
- Start synchroniser: start_ack = start delayed by 2 flops. A rising edge of start_ack (sampled against a third flop) is the launch event.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on a launch event. On entry, addr/col/row are zeroed, and mode, solid_value, scroll and continuous are latched for the whole frame.
  - Launch events arriving while in RUN are ignored.
  - RUN: valid=1. A handshake (valid & ready) advances addr by 1 and col by 1. When col reaches WPR-1, col wraps to 0 and row increments.
  - dout and valid are driven only from registers. dout must stay stable while valid=1 and ready=0.
- Last-word handshake (addr==MAX_ADDR & ready):
  - frame toggles.
  - offset becomes offset+1 (mod 2^PIX_W) if scroll was latched, else 0.
  - done is set next cycle. If done was already 1 and not being acknowledged that cycle, overrun is set.
  - If continuous is latched: stay in RUN and restart at addr 0 next cycle, re-latching mode/solid_value/scroll/continuous. No bubble cycle.
  - Otherwise: go to IDLE with valid=0.
- done/overrun clear: done&done_ack clears both the next cycle. A set and an ack in the same cycle: the set wins.
- Pixel k (0 = LSB slot) of word at (col,row):
  - x = col*PIX_PER_WORD + k.
  - mode 0: (x + offset) mod 2^PIX_W.
  - mode 1: (row + offset) mod 2^PIX_W.
  - mode 2: all-ones if bit 0 of (((x+offset)>>CHK_LOG2) XOR (row>>CHK_LOG2)) is 1, else 0.
  - mode 3: solid_value.
  - Pixel k occupies pixel bits [k*PIX_W +: PIX_W].
- Output fields: mask is all ones; frame is the current frame register; addr is zero-extended to ADDR_W.
- Latency: first valid appears 1 cycle after the launch event.

Test Plan:
- Params IMG_WIDTH=8, IMG_HEIGHT=2, PIX_PER_WORD=4, PIX_W=8; mode 0, ready=1, pulse start -> 4 words, addr 0..3:
  - pixels {03,02,01,00}, {07,06,05,04}, {03,02,01,00}, {07,06,05,04};
  - frame=1 throughout, then 0; done=1 one cycle after addr 3; valid=0 afterwards.
- Same params, ready toggling 1/0 every cycle -> dout constant while ready=0; still exactly 4 handshakes, no skipped or duplicated addresses.
- mode 0 with scroll=1, continuous=1, done_ack tied 1 -> frames alternate frame 1,0,1; second frame word 0 = {04,03,02,01}; no idle cycle between frames; overrun stays 0.
- continuous=1 with done_ack=0 -> second frame end sets overrun=1; one done_ack pulse clears both done and overrun.
- mode 2, CHK_LOG2=1, IMG_WIDTH=8 -> row 0 word 0 = {FF,FF,00,00}; row 2 word 0 = {00,00,FF,FF}. mode 3 with solid_value=5A -> every pixel 5A.
- reset_n low mid-frame (addr=2) -> valid, done and start_ack 0 immediately; frame=1, addr=0; a new start begins at addr 0.
